// File: rtl/vga_px_arbiter.sv
// Arbitrates two pixel-write requesters onto one pixel master: 1-cycle grant latency, slave stalls pass straight back to the granted requester.
// Round-robin when both request; define VGA_PX_ARB_FIXED_PRIO_EN to always favour port 0 instead.
module vga_px_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r0_address,
    input  logic              r0_write,
    input  logic [DATA_W-1:0] r0_writedata,
    output logic              r0_waitrequest,
    input  logic [ADDR_W-1:0] r1_address,
    input  logic              r1_write,
    input  logic [DATA_W-1:0] r1_writedata,
    output logic              r1_waitrequest,
    output logic [ADDR_W-1:0] vga_px_address,
    output logic              vga_px_write,
    output logic [DATA_W-1:0] vga_px_writedata,
    input  logic              vga_px_waitrequest,
    output logic [1:0]        grant_export,
    output logic [7:0]        xfer_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] grant_q;
    logic [7:0] xfer_count_q;
    logic       pick1;

`ifdef VGA_PX_ARB_FIXED_PRIO_EN
    assign pick1 = ~r0_write;
`else
    logic last_grant_q;

    assign pick1 = (r0_write & r1_write) ? ~last_grant_q : ~r0_write;
`endif

    // last_grant tracks every winner, so a port stalled behind a foreign transfer wins the next tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            xfer_count_q <= 8'd0;
`ifndef VGA_PX_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (r0_write | r1_write) begin
                        if (pick1) begin
                            state_q <= GRANT1;
                            grant_q <= 2'b10;
                        end else begin
                            state_q <= GRANT0;
                            grant_q <= 2'b01;
                        end
`ifndef VGA_PX_ARB_FIXED_PRIO_EN
                        last_grant_q <= pick1;
`endif
                    end
                end
                GRANT0: begin
                    if (!r0_write || !vga_px_waitrequest) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        if (r0_write) begin
                            xfer_count_q <= xfer_count_q + 8'd1;
                        end
                    end
                end
                GRANT1: begin
                    if (!r1_write || !vga_px_waitrequest) begin
                        state_q <= IDLE;
                        grant_q <= 2'b00;
                        if (r1_write) begin
                            xfer_count_q <= xfer_count_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        vga_px_address   = '0;
        vga_px_write     = 1'b0;
        vga_px_writedata = '0;
        r0_waitrequest   = 1'b1;
        r1_waitrequest   = 1'b1;
        case (state_q)
            GRANT0: begin
                vga_px_address   = r0_address;
                vga_px_write     = r0_write;
                vga_px_writedata = r0_writedata;
                r0_waitrequest   = vga_px_waitrequest;
            end
            GRANT1: begin
                vga_px_address   = r1_address;
                vga_px_write     = r1_write;
                vga_px_writedata = r1_writedata;
                r1_waitrequest   = vga_px_waitrequest;
            end
            default: ;
        endcase
    end

    assign grant_export = grant_q;
    assign xfer_count   = xfer_count_q;

endmodule

// File: tb/tb_vga_px_arbiter.sv
// Bench for vga_px_arbiter: directed scenarios plus randomized traffic; a negedge monitor checks
// the bus against per-port scoreboard queues and a fairness/transfer-count reference model.
module tb_vga_px_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] r0_address = '0, r1_address = '0;
    logic        r0_write = 1'b0, r1_write = 1'b0;
    logic [15:0] r0_writedata = '0, r1_writedata = '0;
    logic        r0_waitrequest, r1_waitrequest;
    logic [31:0] vga_px_address;
    logic        vga_px_write;
    logic [15:0] vga_px_writedata;
    logic        vga_px_waitrequest;
    logic [1:0]  grant_export;
    logic [7:0]  xfer_count;

    logic [1:0]  slave_mode = 2'd0;  // 0: zero-wait, 1: stall, 2: random
    logic        rand_bit = 1'b0;
    logic        mon_en = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [47:0] q0[$];
    logic [47:0] q1[$];
    logic [7:0]  mdl_cnt = 8'd0;
    logic        last_served = 1'b1;
    logic [1:0]  prev_grant = 2'b00;
    logic [1:0]  prev_w = 2'b00;
    logic        prev_stall = 1'b0;
    logic [1:0]  exp_rr[8] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    vga_px_arbiter #(.ADDR_W(32), .DATA_W(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .r0_address         (r0_address),
        .r0_write           (r0_write),
        .r0_writedata       (r0_writedata),
        .r0_waitrequest     (r0_waitrequest),
        .r1_address         (r1_address),
        .r1_write           (r1_write),
        .r1_writedata       (r1_writedata),
        .r1_waitrequest     (r1_waitrequest),
        .vga_px_address     (vga_px_address),
        .vga_px_write       (vga_px_write),
        .vga_px_writedata   (vga_px_writedata),
        .vga_px_waitrequest (vga_px_waitrequest),
        .grant_export       (grant_export),
        .xfer_count         (xfer_count)
    );

    always #5 clk = ~clk;

    assign vga_px_waitrequest = (slave_mode == 2'd2) ? rand_bit : slave_mode[0];

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_bit = ($urandom_range(0, 99) < 35);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor and reference model.
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                check("rst_write", {63'd0, vga_px_write}, 64'd0);
                check("rst_grant", {62'd0, grant_export}, 64'd0);
                check("rst_wait", {62'd0, r1_waitrequest, r0_waitrequest}, 64'd3);
                check("rst_count", {56'd0, xfer_count}, 64'd0);
                mdl_cnt = 8'd0;
                last_served = 1'b1;
                q0.delete();
                q1.delete();
                prev_grant = 2'b00;
                prev_w = 2'b00;
                prev_stall = 1'b0;
            end else begin
                logic [1:0] exp_g;
                logic [47:0] exp_tx;
                check("count", {56'd0, xfer_count}, {56'd0, mdl_cnt});
                case (grant_export)
                    2'b00: begin
                        check("idle_bus", {15'd0, vga_px_write, vga_px_address, vga_px_writedata}, 64'd0);
                        check("idle_wait", {62'd0, r1_waitrequest, r0_waitrequest}, 64'd3);
                    end
                    2'b01: begin
                        check("g0_bus", {15'd0, vga_px_write, vga_px_address, vga_px_writedata},
                              {15'd0, r0_write, r0_address, r0_writedata});
                        check("g0_wait", {62'd0, r1_waitrequest, r0_waitrequest},
                              {62'd0, 1'b1, vga_px_waitrequest});
                    end
                    2'b10: begin
                        check("g1_bus", {15'd0, vga_px_write, vga_px_address, vga_px_writedata},
                              {15'd0, r1_write, r1_address, r1_writedata});
                        check("g1_wait", {62'd0, r1_waitrequest, r0_waitrequest},
                              {62'd0, vga_px_waitrequest, 1'b1});
                    end
                    default: check("grant_legal", {62'd0, grant_export}, 64'd0);
                endcase
                if (prev_grant == 2'b00) begin
                    if (prev_w != 2'b00) begin
                        exp_g = (prev_w == 2'b11) ? (last_served ? 2'b01 : 2'b10) : prev_w;
                        check("arb", {62'd0, grant_export}, {62'd0, exp_g});
                        last_served = (exp_g == 2'b10);
                    end else begin
                        check("idle_hold", {62'd0, grant_export}, 64'd0);
                    end
                end else if (prev_stall) begin
                    check("stall_hold", {62'd0, grant_export}, {62'd0, prev_grant});
                end else begin
                    check("release", {62'd0, grant_export}, 64'd0);
                end
                if (vga_px_write && !vga_px_waitrequest) begin
                    if (grant_export == 2'b01 && q0.size() != 0) begin
                        exp_tx = q0.pop_front();
                        check("sb_tx0", {16'd0, vga_px_address, vga_px_writedata}, {16'd0, exp_tx});
                    end else if (grant_export == 2'b10 && q1.size() != 0) begin
                        exp_tx = q1.pop_front();
                        check("sb_tx1", {16'd0, vga_px_address, vga_px_writedata}, {16'd0, exp_tx});
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected grant=%b addr=0x%0h data=0x%0h", grant_export,
                                 vga_px_address, vga_px_writedata);
                    end
                    mdl_cnt = mdl_cnt + 8'd1;
                end
                prev_grant = grant_export;
                prev_w = {r1_write, r0_write};
                prev_stall = vga_px_write && vga_px_waitrequest;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        mon_en = 1'b1;
        #1;
        check("rst_async_write", {63'd0, vga_px_write}, 64'd0);
        check("rst_async_grant", {62'd0, grant_export}, 64'd0);
        check("rst_async_wait", {62'd0, r1_waitrequest, r0_waitrequest}, 64'd3);
        check("rst_async_count", {56'd0, xfer_count}, 64'd0);
        r0_write = 1'b0;
        r1_write = 1'b0;
        slave_mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Presents one write and holds it until accepted; leaves write high for back-to-back use.
    task automatic drive(input int p, input logic [31:0] a, input logic [15:0] d);
        bit done = 0;
        if (p == 0) q0.push_back({a, d});
        else        q1.push_back({a, d});
        @(posedge clk);
        #1;
        if (p == 0) begin
            r0_address = a; r0_writedata = d; r0_write = 1'b1;
        end else begin
            r1_address = a; r1_writedata = d; r1_write = 1'b1;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((p == 0) ? !r0_waitrequest : !r1_waitrequest) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drive_timeout port=%0d addr=0x%0h waited=300 cycles", p, a);
        end
    endtask

    task automatic gap(input int p, input int n);
        @(posedge clk);
        #1;
        if (p == 0) r0_write = 1'b0;
        else        r1_write = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    initial begin
        do_reset();

        // Single r0 write with zero-wait slave.
        q0.push_back({32'h0800_0402, 16'h07E0});
        @(posedge clk);
        #1;
        r0_address = 32'h0800_0402; r0_writedata = 16'h07E0; r0_write = 1'b1;
        @(negedge clk);
        check("c1_write", {63'd0, vga_px_write}, 64'd0);
        check("c1_r0wait", {63'd0, r0_waitrequest}, 64'd1);
        @(negedge clk);
        check("c2_write", {63'd0, vga_px_write}, 64'd1);
        check("c2_r0wait", {63'd0, r0_waitrequest}, 64'd0);
        check("c2_addr", {32'd0, vga_px_address}, 64'h0800_0402);
        check("c2_data", {48'd0, vga_px_writedata}, 64'h07E0);
        check("c2_grant", {62'd0, grant_export}, 64'd1);
        @(posedge clk);
        #1;
        r0_write = 1'b0;
        @(negedge clk);
        check("c3_count", {56'd0, xfer_count}, 64'd1);
        check("c3_grant", {62'd0, grant_export}, 64'd0);

        // Simultaneous held requests alternate r0, r1, r0, r1.
        do_reset();
        q0.push_back({32'h100, 16'h1}); q0.push_back({32'h100, 16'h1});
        q1.push_back({32'h200, 16'h2}); q1.push_back({32'h200, 16'h2});
        @(posedge clk);
        #1;
        r0_address = 32'h100; r0_writedata = 16'h1; r0_write = 1'b1;
        r1_address = 32'h200; r1_writedata = 16'h2; r1_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_grant", {62'd0, grant_export}, {62'd0, exp_rr[i]});
        end
        @(posedge clk);
        #1;
        r0_write = 1'b0; r1_write = 1'b0;
        @(negedge clk);
        check("rr_count", {56'd0, xfer_count}, 64'd4);

        // Five stalled cycles during GRANT1.
        do_reset();
        slave_mode = 2'd1;
        q1.push_back({32'hABCD_0010, 16'hF81F});
        @(posedge clk);
        #1;
        r1_address = 32'hABCD_0010; r1_writedata = 16'hF81F; r1_write = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_r1wait", {63'd0, r1_waitrequest}, 64'd1);
            check("stall_grant", {62'd0, grant_export}, 64'd2);
            check("stall_bus", {16'd0, vga_px_address, vga_px_writedata}, {16'd0, 32'hABCD_0010, 16'hF81F});
        end
        @(posedge clk);
        #1;
        slave_mode = 2'd0;
        @(negedge clk);
        check("stall_done_wait", {63'd0, r1_waitrequest}, 64'd0);
        @(posedge clk);
        #1;
        r1_write = 1'b0;
        @(negedge clk);
        check("stall_count", {56'd0, xfer_count}, 64'd1);

        // r0 abandons its write while stalled.
        do_reset();
        slave_mode = 2'd1;
        @(posedge clk);
        #1;
        r0_address = 32'h55; r0_writedata = 16'h66; r0_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("drop_grant", {62'd0, grant_export}, 64'd1);
        @(posedge clk);
        #1;
        r0_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("drop_idle", {62'd0, grant_export}, 64'd0);
        check("drop_count", {56'd0, xfer_count}, 64'd0);

        // Reset lands in the middle of a stalled GRANT0.
        do_reset();
        slave_mode = 2'd1;
        @(posedge clk);
        #1;
        r0_address = 32'h77; r0_writedata = 16'h88; r0_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_write", {63'd0, vga_px_write}, 64'd1);
        do_reset();
        @(negedge clk);
        check("mid_count", {56'd0, xfer_count}, 64'd0);

        // 256 r1 writes wrap the counter back to zero.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            drive(1, 32'h1000 + i, 16'(i));
        end
        gap(1, 0);
        @(negedge clk);
        check("wrap_count", {56'd0, xfer_count}, 64'd0);

        // Randomized traffic from both requesters against a random-stall slave.
        do_reset();
        slave_mode = 2'd2;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    if ($urandom_range(0, 2) == 0) gap(0, $urandom_range(0, 3));
                    drive(0, $urandom, 16'($urandom_range(0, 65535)));
                end
                gap(0, 0);
            end
            begin
                for (int j = 0; j < 120; j++) begin
                    if ($urandom_range(0, 2) == 0) gap(1, $urandom_range(0, 3));
                    drive(1, $urandom, 16'($urandom_range(0, 65535)));
                end
                gap(1, 0);
            end
        join
        slave_mode = 2'd0;
        repeat (4) @(negedge clk);
        check("sb_drain", 64'(q0.size() + q1.size()), 64'd0);
        check("rand_count", {56'd0, xfer_count}, 64'd240);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_px_arbiter.md
VGA_PX_ARBITER -- requirements
Module: vga_px_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: pixel address width for all ports.
REQ-002 SHALL have parameter DATA_W, default 16: pixel colour width for all ports.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports r0_address / r0_write / r0_writedata, inputs, ADDR_W/1/DATA_W: requester 0 (game command writes).
REQ-006 SHALL have port r0_waitrequest, output, 1: stall to requester 0.
REQ-007 SHALL have ports r1_address / r1_write / r1_writedata, inputs, ADDR_W/1/DATA_W: requester 1 (screen clear / background fill).
REQ-008 SHALL have port r1_waitrequest, output, 1: stall to requester 1.
REQ-009 SHALL have ports vga_px_address / vga_px_write / vga_px_writedata, outputs, ADDR_W/1/DATA_W: shared pixel master.
REQ-010 SHALL have port vga_px_waitrequest, input, 1: stall from the pixel buffer slave.
REQ-011 SHALL have port grant_export, output, 2: one-hot current grant {g1,g0}; 00 when idle.
REQ-012 SHALL have port xfer_count, output, 8: count of completed pixel writes.

Function
REQ-013 SHALL implement states IDLE, GRANT0, GRANT1, held in a registered state variable.
REQ-014 IDLE: SHALL drive vga_px_write=0, vga_px_address=0, vga_px_writedata=0, both rX_waitrequest=1.
REQ-015 IDLE, only rN_write high: SHALL move to GRANTN next cycle (1-cycle arbitration latency).
REQ-016 IDLE, both writes high: SHALL grant the port not equal to last_grant (round-robin) and update last_grant to the winner.
REQ-017 GRANTN: SHALL combinationally pass rN_address/rN_write/rN_writedata to vga_px_*; other requester's waitrequest SHALL be 1.
REQ-018 GRANTN: rN_waitrequest SHALL equal vga_px_waitrequest (same cycle).
REQ-019 Transfer completes in the cycle rN_write=1 and vga_px_waitrequest=0; SHALL return to IDLE next cycle and increment xfer_count.
REQ-020 GRANTN with rN_write dropped before completion (protocol violation): SHALL return to IDLE next cycle, no count increment.
REQ-021 Grant SHALL never change while vga_px_write=1 and vga_px_waitrequest=1.
REQ-022 A request arriving while the other port is granted SHALL stall and be served at the next IDLE; each port waits at most one foreign transfer.
REQ-023 xfer_count SHALL wrap 255 -> 0 with no flag.
REQ-024 grant_export SHALL be 01 in GRANT0, 10 in GRANT1, 00 in IDLE.
REQ-025 Sustained throughput SHALL be one write per 2 cycles with zero-wait slave.

Reset
REQ-026 reset high SHALL immediately (asynchronously) force state=IDLE, last_grant=1, xfer_count=0.
REQ-027 Hence during reset: vga_px_write=0, both rX_waitrequest=1, grant_export=00.
REQ-028 Reset mid-transfer SHALL abort it with no count increment; first grant after release SHALL go to port 0 if both request.

Configuration
REQ-029 Macro VGA_PX_ARB_FIXED_PRIO_EN defined: IDLE with both requests SHALL always grant port 0; last_grant unused.
REQ-030 Macro undefined: SHALL use round-robin per REQ-016.

Verification
REQ-031 r0 write addr 0x0800_0402 data 0x07E0, slave zero-wait -> vga_px_write high cycle 2, r0_waitrequest low cycle 2, xfer_count=1.
REQ-032 r0 and r1 request same cycle after reset, both held -> order r0, r1, r0, r1; grant_export 01,00,10,00,...; with FIXED_PRIO_EN only r0 served until it drops.
REQ-033 Slave waitrequest high 5 cycles during GRANT1 -> r1_waitrequest high 5 cycles, address/data stable, grant unchanged, completes cycle 6.
REQ-034 reset asserted mid-GRANT0 with slave stalling -> vga_px_write=0 same cycle, xfer_count=0, state IDLE.
REQ-035 256 single r1 writes -> xfer_count returns to 0.
REQ-036 r0 drops write in GRANT0 before acceptance -> IDLE next cycle, xfer_count unchanged.
